// File: rtl/mem_issue_pkg.sv
// Shared types and lane helpers for the EX->MEM load/store issue unit.
package mem_issue_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Per-request bookkeeping carried until the response returns.
    typedef struct packed {
        logic       store;
        logic [1:0] size;
        logic       sgn;
        logic [1:0] lo;
    } mem_meta_t;

    function automatic logic [3:0] lane_strb(logic store, logic [1:0] size, logic [1:0] lo);
        logic [3:0] s;
        s = 4'b0000;
        if (store) begin
            case (size)
                SZ_B:    s = 4'b0001 << lo;
                SZ_H:    s = lo[1] ? 4'b1100 : 4'b0011;
                default: s = 4'b1111;
            endcase
        end
        return s;
    endfunction

    function automatic logic [31:0] load_extend(logic [31:0] rdata, logic [1:0] size,
                                                logic sgn, logic [1:0] lo);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {lo, 3'b000};
        case (size)
            SZ_B:    r = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_H:    r = {{16{sgn & sh[15]}}, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_issue_fifo.sv
// In-order tracking FIFO for outstanding bus requests, with per-entry cancel
// bits that a flush can set in bulk.
module mem_issue_fifo
    import mem_issue_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  mem_meta_t         push_meta,
    input  logic [DEST_W-1:0] push_dest,
    input  logic              push_cancel,
    input  logic              pop,
    input  logic              cancel_all,
    output mem_meta_t         head_meta,
    output logic [DEST_W-1:0] head_dest,
    output logic              head_cancel,
    output logic              empty,
    output logic              full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    mem_meta_t         meta_q [DEPTH];
    logic [DEST_W-1:0] dest_q [DEPTH];
    logic [DEPTH-1:0]  cancel_q;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop & ~empty;

    assign head_meta   = meta_q[rd_ptr];
    assign head_dest   = dest_q[rd_ptr];
    assign head_cancel = cancel_q[rd_ptr];

    function automatic logic [PW-1:0] next_ptr(logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)
                rd_ptr <= next_ptr(rd_ptr);
            if (push && !do_pop)
                count <= count + CW'(1);
            else if (!push && do_pop)
                count <= count - CW'(1);
        end
    end

    // Cancelling empty slots is harmless: a later push overwrites the bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cancel_q <= '0;
        end else begin
            if (cancel_all)
                cancel_q <= '1;
            if (push)
                cancel_q[wr_ptr] <= push_cancel;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            meta_q[wr_ptr] <= push_meta;
            dest_q[wr_ptr] <= push_dest;
        end
    end

endmodule

// File: rtl/ex_mem_issue.sv
// Pipelined load/store issue unit between EX and the req/addr_ok/data_ok bus.
// Define EX_MEM_ISSUE_ALE_EN to enable misalignment (ALE) detection.
module ex_mem_issue
    import mem_issue_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int ADDR_W      = 32,
    parameter int DEST_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              st_block,
    input  logic              flush,
    output logic              req,
    output logic              wr,
    output logic [2:0]        size,
    output logic [3:0]        wstrb,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [31:0]       rdata,
    output logic              ale,
    output logic              rsp_valid,
    output logic              rsp_store,
    output logic [DEST_W-1:0] rsp_dest,
    output logic [31:0]       rsp_data,
    output logic              busy
);

    logic              blk_r;
    logic              suppress;
    logic              push;
    logic              pop;
    logic              deliver;
    logic              fifo_empty;
    logic              fifo_full;
    logic              head_cancel;
    mem_meta_t         push_meta;
    mem_meta_t         head_meta;
    logic [DEST_W-1:0] head_dest;

`ifdef EX_MEM_ISSUE_ALE_EN
    assign ale = in_valid & (((in_size == SZ_H) & in_addr[0]) |
                             ((in_size == SZ_W) & (in_addr[1:0] != 2'b00)));
`else
    assign ale = 1'b0;
`endif

    assign suppress = in_store & (st_block | blk_r);
    assign req      = in_valid & ~ale & ~suppress & ~fifo_full & ~flush;
    assign push     = req & addr_ok;
    // Dropped ops (ALE, suppressed stores) are consumed without a bus access.
    assign in_ready = in_valid & (ale | suppress | push);

    assign wr    = in_store;
    assign size  = {1'b0, in_size};
    assign addr  = in_addr;
    assign wstrb = lane_strb(in_store, in_size, in_addr[1:0]);

    always_comb begin
        wdata = in_wdata;
        case (in_size)
            SZ_B:    wdata = {4{in_wdata[7:0]}};
            SZ_H:    wdata = {2{in_wdata[15:0]}};
            default: wdata = in_wdata;
        endcase
    end

    assign push_meta = '{store: in_store, size: in_size, sgn: in_signed, lo: in_addr[1:0]};

    mem_issue_fifo #(
        .DEPTH  (OUTSTANDING),
        .DEST_W (DEST_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_meta   (push_meta),
        .push_dest   (in_dest),
        .push_cancel (flush),
        .pop         (data_ok),
        .cancel_all  (flush),
        .head_meta   (head_meta),
        .head_dest   (head_dest),
        .head_cancel (head_cancel),
        .empty       (fifo_empty),
        .full        (fifo_full)
    );

    assign busy = ~fifo_empty;
    assign pop  = data_ok & ~fifo_empty;
    // A flush landing on the same cycle as data_ok also kills the head entry.
    assign deliver = pop & ~head_cancel & ~flush;

    always_ff @(posedge clk) begin
        if (reset)
            blk_r <= 1'b0;
        else if (flush)
            blk_r <= 1'b0;
        else if (st_block)
            blk_r <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_store <= 1'b0;
            rsp_dest  <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= deliver;
            if (deliver) begin
                rsp_store <= head_meta.store;
                rsp_dest  <= head_dest;
                rsp_data  <= head_meta.store ? 32'h0 :
                             load_extend(rdata, head_meta.size, head_meta.sgn, head_meta.lo);
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_issue.sv
// Directed bench for ex_mem_issue: handshakes, lanes, extension, flush, block.
module tb_ex_mem_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_store, in_signed;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_dest;
    logic        st_block, flush;
    logic        req, wr;
    logic [2:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic        ale, rsp_valid, rsp_store, busy;
    logic [4:0]  rsp_dest;
    logic [31:0] rsp_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_mem_issue #(.OUTSTANDING(2), .ADDR_W(32), .DEST_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_store(in_store),
        .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_dest(in_dest),
        .st_block(st_block), .flush(flush),
        .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .ale(ale), .rsp_valid(rsp_valid), .rsp_store(rsp_store),
        .rsp_dest(rsp_dest), .rsp_data(rsp_data), .busy(busy)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(logic st, logic [1:0] sz, logic sg, logic [31:0] a,
                      logic [31:0] wd, logic [4:0] d);
        in_valid = 1'b1; in_store = st; in_size = sz; in_signed = sg;
        in_addr = a; in_wdata = wd; in_dest = d;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_store = 1'b0; in_size = 2'b00; in_signed = 1'b0;
        in_addr = '0; in_wdata = '0; in_dest = '0;
    endtask

    initial begin
        reset = 1'b1; idle();
        st_block = 1'b0; flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
        cyc(); cyc();
        #1;
        chk("rst_req", req, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_store", rsp_store, 0);
        chk("rst_rsp_dest", rsp_dest, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        cyc();

        // st.b 0x1003
        op(1, 2'b00, 0, 32'h1003, 32'h1234_56A5, 0); addr_ok = 1'b1;
        #1;
        chk("stb_req", req, 1);
        chk("stb_wr", wr, 1);
        chk("stb_size", size, 3'b000);
        chk("stb_wstrb", wstrb, 4'b1000);
        chk("stb_wdata", wdata, 32'hA5A5_A5A5);
        chk("stb_in_ready", in_ready, 1);
        cyc();
        idle(); addr_ok = 1'b0;
        chk("stb_busy", busy, 1);
        data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
        cyc();
        data_ok = 1'b0;
        chk("stb_rsp_valid", rsp_valid, 1);
        chk("stb_rsp_store", rsp_store, 1);
        chk("stb_rsp_data", rsp_data, 0);
        chk("stb_busy_after", busy, 0);
        cyc();
        chk("stb_rsp_pulse", rsp_valid, 0);

        // st.h 0x1002 lanes, no handshake
        op(1, 2'b01, 0, 32'h1002, 32'hCAFE_BEEF, 0);
        #1;
        chk("sth_wstrb", wstrb, 4'b1100);
        chk("sth_wdata", wdata, 32'hBEEF_BEEF);
        chk("sth_wait_ready", in_ready, 0);
        idle();

        // ld.h 0x1002 signed / unsigned, ld.b 0x1001 signed
        op(0, 2'b01, 1, 32'h1002, 0, 5'd7); addr_ok = 1'b1;
        #1;
        chk("ldh_req", req, 1);
        chk("ldh_wstrb", wstrb, 4'b0000);
        cyc();
        idle(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h8001_7FFF;
        cyc();
        data_ok = 1'b0;
        chk("ldh_s_valid", rsp_valid, 1);
        chk("ldh_s_dest", rsp_dest, 7);
        chk("ldh_s_data", rsp_data, 32'hFFFF_8001);
        op(0, 2'b01, 0, 32'h1002, 0, 5'd9); addr_ok = 1'b1;
        cyc();
        idle(); addr_ok = 1'b0; data_ok = 1'b1;
        cyc();
        data_ok = 1'b0;
        chk("ldh_u_dest", rsp_dest, 9);
        chk("ldh_u_data", rsp_data, 32'h0000_8001);
        op(0, 2'b00, 1, 32'h1001, 0, 5'd3); addr_ok = 1'b1;
        cyc();
        idle(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0000_8000;
        cyc();
        data_ok = 1'b0;
        chk("ldb_s_data", rsp_data, 32'hFFFF_FF80);

        // ld.w 0x1001 misaligned
        op(0, 2'b10, 0, 32'h1001, 0, 5'd4);
        #1;
`ifdef EX_MEM_ISSUE_ALE_EN
        chk("ale_flag", ale, 1);
        chk("ale_in_ready", in_ready, 1);
        chk("ale_req", req, 0);
        cyc();
        idle();
        chk("ale_no_entry", busy, 0);
`else
        chk("ale_off_flag", ale, 0);
        chk("ale_off_req", req, 1);
        idle();
        cyc();
`endif

        // 4 back-to-back loads, data_ok 3 cycles after addr_ok
        addr_ok = 1'b1;
        op(0, 2'b10, 0, 32'h2000, 0, 5'd1);
        #1; chk("b2b_req0", req, 1);
        cyc();
        op(0, 2'b10, 0, 32'h2004, 0, 5'd2);
        #1; chk("b2b_req1", req, 1);
        cyc();
        op(0, 2'b10, 0, 32'h2008, 0, 5'd3);
        #1; chk("b2b_full_req", req, 0); chk("b2b_full_ready", in_ready, 0);
        cyc();
        data_ok = 1'b1; rdata = 32'h1111_0001;
        #1; chk("b2b_nobypass_req", req, 0);
        cyc();
        chk("b2b_rsp1_valid", rsp_valid, 1);
        chk("b2b_rsp1_dest", rsp_dest, 1);
        chk("b2b_rsp1_data", rsp_data, 32'h1111_0001);
        rdata = 32'h2222_0002;
        #1; chk("b2b_req2", req, 1);
        cyc();
        chk("b2b_rsp2_dest", rsp_dest, 2);
        chk("b2b_rsp2_data", rsp_data, 32'h2222_0002);
        op(0, 2'b10, 0, 32'h200C, 0, 5'd4); data_ok = 1'b0;
        #1; chk("b2b_req3", req, 1);
        cyc();
        chk("b2b_gap", rsp_valid, 0);
        idle(); addr_ok = 1'b0;
        cyc();
        data_ok = 1'b1; rdata = 32'h3333_0003;
        cyc();
        chk("b2b_rsp3_dest", rsp_dest, 3);
        chk("b2b_rsp3_data", rsp_data, 32'h3333_0003);
        rdata = 32'h4444_0004;
        cyc();
        data_ok = 1'b0;
        chk("b2b_rsp4_dest", rsp_dest, 4);
        chk("b2b_rsp4_data", rsp_data, 32'h4444_0004);
        chk("b2b_busy_done", busy, 0);

        // flush with two loads in flight
        addr_ok = 1'b1;
        op(0, 2'b10, 0, 32'h3000, 0, 5'd10);
        cyc();
        op(0, 2'b10, 0, 32'h3004, 0, 5'd11);
        cyc();
        addr_ok = 1'b1; flush = 1'b1;
        op(0, 2'b10, 0, 32'h3008, 0, 5'd12);
        #1; chk("fl_req_flush", req, 0);
        cyc();
        flush = 1'b0; idle(); addr_ok = 1'b0; data_ok = 1'b1;
        cyc();
        chk("fl_rsp_a", rsp_valid, 0);
        cyc();
        data_ok = 1'b0;
        chk("fl_rsp_b", rsp_valid, 0);
        chk("fl_busy", busy, 0);
        op(0, 2'b10, 0, 32'h3008, 0, 5'd12); addr_ok = 1'b1;
        cyc();
        idle(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1234_5678;
        cyc();
        chk("fl_post_valid", rsp_valid, 1);
        chk("fl_post_dest", rsp_dest, 12);
        chk("fl_post_data", rsp_data, 32'h1234_5678);
        cyc();
        data_ok = 1'b0;
        chk("empty_dok_valid", rsp_valid, 0);
        chk("empty_dok_busy", busy, 0);

        // sticky store block
        st_block = 1'b1;
        cyc();
        st_block = 1'b0; addr_ok = 1'b1;
        op(1, 2'b10, 0, 32'h4000, 32'h0BAD_F00D, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("blk_req", req, 0);
            chk("blk_ready", in_ready, 1);
            cyc();
        end
        op(0, 2'b10, 0, 32'h4000, 0, 5'd5); addr_ok = 1'b0;
        #1; chk("blk_load_req", req, 1);
        op(1, 2'b10, 0, 32'h4000, 32'h0BAD_F00D, 0); addr_ok = 1'b1; flush = 1'b1;
        #1; chk("blk_flush_req", req, 0);
        cyc();
        flush = 1'b0;
        #1; chk("blk_post_req", req, 1); chk("blk_post_ready", in_ready, 1);
        cyc();
        idle(); addr_ok = 1'b0;
        chk("blk_post_busy", busy, 1);
        data_ok = 1'b1;
        cyc();
        data_ok = 1'b0;
        chk("blk_post_rsp", rsp_valid, 1);
        chk("blk_post_store", rsp_store, 1);

        // reset mid-operation
        op(0, 2'b10, 0, 32'h5000, 0, 5'd6); addr_ok = 1'b1;
        cyc();
        idle(); addr_ok = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        data_ok = 1'b1;
        cyc();
        data_ok = 1'b0;
        chk("midrst_rsp", rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
